// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam int          INSTR_W = 32;

  // Opcode field position inside the instruction word.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // Branch displacement: sign-extended 16-bit word offset, scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/ack plus the decode side.
// Latency: n/a (wiring only).
// Backpressure: imem_req is held until imem_ack; decode holds instr_valid until retire.
// master = fetch unit; slave = memory/decode environment.
interface ifetch_if;
  import ifetch_unit_pkg::*;

  // instruction memory side
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  // decode side
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         opcode;
  logic [31:0]        pc_out;
  logic [31:0]        pc_plus4;
  logic               retire;
  logic               is_beq;
  logic               jmp;
  logic               alu_zero;
  // status
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4, fetch_err,
    input  imem_ack, imem_rdata, retire, is_beq, jmp, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4, fetch_err,
    output imem_ack, imem_rdata, retire, is_beq, jmp, alu_zero
  );

endinterface

// File: rtl/ifetch_unit_next_pc_sel.sv
// Next-PC selection: jump target, taken-beq target or sequential PC.
// Latency: combinational.
// Backpressure: none.
// Ports: pc_plus4, ir_low (IR[25:0]), is_beq, jmp, alu_zero in; next_pc out.
module ifetch_unit_next_pc_sel
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] ir_low,
  input  logic        is_beq,
  input  logic        jmp,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic [31:0] jmp_target;
  logic [31:0] br_target;

  // Jump keeps the 256 MB region of the sequential PC.
  assign jmp_target = {pc_plus4[31:28], ir_low, 2'b00};
  // Wraps mod 2^32 by plain 32-bit addition.
  assign br_target  = pc_plus4 + branch_offset(ir_low[15:0]);

  always_comb begin
    next_pc = pc_plus4;
    if (jmp) begin
      next_pc = jmp_target;
    end else if (is_beq && alu_zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: holds PC, fetches one instruction at a time, presents it to decode.
// Latency: instr_valid the cycle after imem_ack; next request the cycle after retire.
// Backpressure: imem_req held until ack (timeout -> sticky fetch_err); IR held until retire.
// Ports: clk, rst (sync, active-high), bus (ifetch_if.master: imem req/ack, decode, status).
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [31:0]        pc;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   wait_cnt;
  logic               fetch_err;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;

  assign pc_plus4 = pc + PC_INC;

  ifetch_unit_next_pc_sel u_next_pc_sel (
    .pc_plus4 (pc_plus4),
    .ir_low   (ir[25:0]),
    .is_beq   (bus.is_beq),
    .jmp      (bus.jmp),
    .alu_zero (bus.alu_zero),
    .next_pc  (next_pc)
  );

  // Next-state logic. An ack on the timeout cycle wins over the error.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (bus.imem_ack) begin
          state_nxt = HOLD;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = ERR;
        end
      end
      HOLD: begin
        if (bus.retire) begin
          state_nxt = FETCH;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (bus.imem_ack) begin
            ir <= bus.imem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_LAST) begin
              fetch_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.retire) begin
            pc       <= next_pc;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low during the reset cycle so a stale request is dropped at once.
  assign bus.imem_req    = !rst && (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = !rst && (state == HOLD);
  assign bus.instr       = ir;
  assign bus.opcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.pc_out      = pc;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_err   = fetch_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table for fetch/retire chains plus
// hand-written timeout, reset and spurious-ack sequences.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ifetch_if bus();

  ifetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          delay;     // cycles of req without ack before the ack cycle
    logic        jmp;
    logic        is_beq;
    logic        alu_zero;
    logic [5:0]  exp_opcode;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk1("wait_req", bus.imem_req, 1'b1);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    wait_req();
    chk("req_addr", bus.imem_addr, v.exp_pc);
    for (int d = 0; d < v.delay; d++) begin
      tick();
      chk1("wait_req_held", bus.imem_req, 1'b1);
      chk("wait_addr_stable", bus.imem_addr, v.exp_pc);
      chk1("wait_no_err", bus.fetch_err, 1'b0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.rdata;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    chk1("hold_valid", bus.instr_valid, 1'b1);
    chk1("hold_req_low", bus.imem_req, 1'b0);
    chk("hold_instr", bus.instr, v.rdata);
    chk("hold_opcode", {26'd0, bus.opcode}, {26'd0, v.exp_opcode});
    chk("hold_pc_out", bus.pc_out, v.exp_pc);
    chk("hold_pc_plus4", bus.pc_plus4, v.exp_pc + 32'd4);
    chk1("hold_no_err", bus.fetch_err, 1'b0);
    bus.retire   = 1'b1;
    bus.jmp      = v.jmp;
    bus.is_beq   = v.is_beq;
    bus.alu_zero = v.alu_zero;
    tick();
    bus.retire   = 1'b0;
    bus.jmp      = 1'b0;
    bus.is_beq   = 1'b0;
    bus.alu_zero = 1'b0;
    chk1("retire_valid_low", bus.instr_valid, 1'b0);
    chk1("retire_req", bus.imem_req, 1'b1);
    chk("next_addr", bus.imem_addr, v.exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rdata         dly j  beq z  op     pc             next
    vecs[0] = '{32'h2008_0005,  0, 0, 0, 0, 6'h08, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0800_0010,  5, 1, 0, 0, 6'h02, 32'h0000_0004, 32'h0000_0040};
    vecs[2] = '{32'h1000_FFFE,  1, 0, 1, 1, 6'h04, 32'h0000_0040, 32'h0000_003C};
    vecs[3] = '{32'h1000_FFFE, 15, 0, 1, 0, 6'h04, 32'h0000_003C, 32'h0000_0040};
    vecs[4] = '{32'h1000_FFEB,  0, 0, 1, 1, 6'h04, 32'h0000_0040, 32'hFFFF_FFF0};
    vecs[5] = '{32'h0800_0004,  2, 1, 0, 0, 6'h02, 32'hFFFF_FFF0, 32'hF000_0010};
    vecs[6] = '{32'h0800_0100,  3, 1, 1, 1, 6'h02, 32'hF000_0010, 32'hF000_0400};
    vecs[7] = '{32'h8C22_0004,  0, 0, 0, 1, 6'h23, 32'hF000_0400, 32'hF000_0404};

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.retire     = 1'b0;
    bus.is_beq     = 1'b0;
    bus.jmp        = 1'b0;
    bus.alu_zero   = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk1("rst_err", bus.fetch_err, 1'b0);
    chk("rst_ir", bus.instr, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    rst = 1'b0;
    #1;
    chk1("post_rst_req", bus.imem_req, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Timeout at F000_0404: 15 silent cycles still fetching, 16th raises the error.
    wait_req();
    for (int c = 0; c < 15; c++) begin
      tick();
      chk1("to_req_held", bus.imem_req, 1'b1);
      chk1("to_no_err", bus.fetch_err, 1'b0);
    end
    tick();
    chk1("to_err", bus.fetch_err, 1'b1);
    chk1("to_req_low", bus.imem_req, 1'b0);
    chk1("to_valid_low", bus.instr_valid, 1'b0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_ack   = 1'b0;
    tick();
    chk1("err_sticky", bus.fetch_err, 1'b1);
    chk1("err_req_low", bus.imem_req, 1'b0);
    chk1("err_valid_low", bus.instr_valid, 1'b0);
    chk("err_ir_kept", bus.instr, 32'h8C22_0004);
    rst = 1'b1;
    tick();
    chk1("err_rst_clear", bus.fetch_err, 1'b0);
    chk("err_rst_pc", bus.pc_out, 32'h0);
    rst = 1'b0;
    #1;
    chk1("err_rst_req", bus.imem_req, 1'b1);
    chk("err_rst_addr", bus.imem_addr, 32'h0);

    // Spurious ack in HOLD, then reset in HOLD.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    tick();
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack   = 1'b0;
    chk1("spur_valid", bus.instr_valid, 1'b1);
    chk("spur_instr", bus.instr, 32'h2008_0005);
    chk1("spur_req_low", bus.imem_req, 1'b0);
    rst = 1'b1;
    #1;
    chk1("hold_rst_req", bus.imem_req, 1'b0);
    chk1("hold_rst_valid", bus.instr_valid, 1'b0);
    tick();
    chk1("hold_rst_req2", bus.imem_req, 1'b0);
    chk1("hold_rst_valid2", bus.instr_valid, 1'b0);
    chk("hold_rst_ir", bus.instr, 32'h0);
    rst = 1'b0;
    #1;
    chk1("hold_rst_refetch", bus.imem_req, 1'b1);
    chk("hold_rst_addr", bus.imem_addr, 32'h0);

    // Reset mid-FETCH at 0x4.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    tick();
    bus.imem_ack   = 1'b0;
    bus.retire     = 1'b1;
    tick();
    bus.retire     = 1'b0;
    chk("mf_addr", bus.imem_addr, 32'h4);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("mf_rst_req", bus.imem_req, 1'b0);
    tick();
    chk1("mf_rst_req2", bus.imem_req, 1'b0);
    chk1("mf_rst_valid", bus.instr_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("mf_refetch", bus.imem_req, 1'b1);
    chk("mf_refetch_addr", bus.imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
